// File: rtl/dice_pkg.sv
// Shared constants, state encoding and LFSR step function for the dice roller.
package dice_pkg;

    localparam int LFSR_W = 7;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h7F;

    // Feedback taps for the maximal-length 7-bit sequence (period 127)
    localparam int TAP_A = 6;
    localparam int TAP_B = 5;

    localparam logic [2:0] DICE_MIN = 3'd1;
    localparam logic [2:0] DICE_MAX = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[TAP_A] ^ v[TAP_B]};
    endfunction

endpackage

// File: rtl/dice_rng_lfsr7.sv
// Free-running 7-bit Fibonacci LFSR (module lfsr7); seed load only with DICE_RNG_SEED_EN.
module lfsr7
    import dice_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
`ifdef DICE_RNG_SEED_EN
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
`endif
    output logic [LFSR_W-1:0] o_lfsr
);

    logic [LFSR_W-1:0] r_lfsr;

    // A zero seed would lock the register, so it is replaced by the reset seed
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= LFSR_SEED;
        end
`ifdef DICE_RNG_SEED_EN
        else if (i_load) begin
            r_lfsr <= (i_seed == '0) ? LFSR_SEED : i_seed;
        end
`endif
        else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/dice_rng.sv
// Button-driven die roller: edge detect, IDLE/DRAW/DONE draw FSM and registered outputs.
// Optional seed load port pair enabled by DICE_RNG_SEED_EN.
module dice_rng
    import dice_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ROLL,
`ifdef DICE_RNG_SEED_EN
    input  logic              SEED_LOAD,
    input  logic [LFSR_W-1:0] SEED,
`endif
    output logic [LFSR_W-1:0] lfsr_result,
    output logic [2:0]        DICE,
    output logic              VALID,
    output logic              BUSY
);

    logic [LFSR_W-1:0] w_lfsr;
    logic [2:0]        w_cand;
    logic              w_rise;
    logic              w_cand_ok;

    logic              r_roll_q;
    state_t            r_state;
    logic [LFSR_W-1:0] r_result;
    logic [2:0]        r_dice;
    logic              r_valid;
    logic              r_busy;

`ifdef DICE_RNG_SEED_EN
    logic w_load;
    assign w_load = SEED_LOAD && (r_state == IDLE);

    lfsr7 u_lfsr (
        .i_clk  (CLK),
        .i_rst  (RESET),
        .i_load (w_load),
        .i_seed (SEED),
        .o_lfsr (w_lfsr)
    );
`else
    lfsr7 u_lfsr (
        .i_clk  (CLK),
        .i_rst  (RESET),
        .o_lfsr (w_lfsr)
    );
`endif

    assign w_rise    = ROLL & ~r_roll_q;
    assign w_cand    = w_lfsr[2:0];
    assign w_cand_ok = (w_cand >= DICE_MIN) && (w_cand <= DICE_MAX);

    // Rejected candidates (0 or 7) keep the FSM in DRAW while the LFSR keeps stepping
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_roll_q <= 1'b0;
            r_state  <= IDLE;
            r_result <= LFSR_SEED;
            r_dice   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_roll_q <= ROLL;
            r_valid  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= DRAW;
                        r_busy  <= 1'b1;
                    end
                end
                DRAW: begin
                    if (w_cand_ok) begin
                        r_dice   <= w_cand;
                        r_result <= w_lfsr;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign lfsr_result = r_result;
    assign DICE        = r_dice;
    assign VALID       = r_valid;
    assign BUSY        = r_busy;

endmodule

// File: tb/tb_dice_rng.sv
// Directed self-checking bench for dice_rng; seed-load section builds with DICE_RNG_SEED_EN.
module tb_dice_rng;

    logic       CLK;
    logic       RESET;
    logic       ROLL;
    logic [6:0] lfsr_result;
    logic [2:0] DICE;
    logic       VALID;
    logic       BUSY;
`ifdef DICE_RNG_SEED_EN
    logic       SEED_LOAD;
    logic [6:0] SEED;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

`ifdef DICE_RNG_SEED_EN
    dice_rng dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ROLL        (ROLL),
        .SEED_LOAD   (SEED_LOAD),
        .SEED        (SEED),
        .lfsr_result (lfsr_result),
        .DICE        (DICE),
        .VALID       (VALID),
        .BUSY        (BUSY)
    );
`else
    dice_rng dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ROLL        (ROLL),
        .lfsr_result (lfsr_result),
        .DICE        (DICE),
        .VALID       (VALID),
        .BUSY        (BUSY)
    );
`endif

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle to the falling edge where outputs are sampled
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    int unsigned cnt;
    int unsigned n;

    initial begin
        RESET = 1'b1;
        ROLL  = 1'b0;
`ifdef DICE_RNG_SEED_EN
        SEED_LOAD = 1'b0;
        SEED      = '0;
`endif
        repeat (4) step();
        check_eq("rst_result", lfsr_result, 7'h7F);
        check_eq("rst_dice", DICE, 3'd0);
        check_eq("rst_valid", VALID, 1'b0);
        check_eq("rst_busy", BUSY, 1'b0);

        // Immediate accept: ROLL sampled at e1, candidate 7E -> 6
        RESET = 1'b0;
        ROLL  = 1'b1;
        step();
        check_eq("acc_e1_busy", BUSY, 1'b1);
        check_eq("acc_e1_valid", VALID, 1'b0);
        check_eq("acc_e1_dice", DICE, 3'd0);
        step();
        check_eq("acc_e2_valid", VALID, 1'b1);
        check_eq("acc_e2_dice", DICE, 3'd6);
        check_eq("acc_e2_result", lfsr_result, 7'h7E);
        check_eq("acc_e2_busy", BUSY, 1'b1);
        ROLL = 1'b0;
        step();
        check_eq("acc_e3_valid", VALID, 1'b0);
        check_eq("acc_e3_busy", BUSY, 1'b0);
        check_eq("acc_e3_dice", DICE, 3'd6);

        // Rejection: ROLL at e3, 78/70/60/40 rejected, 01 accepted at e8
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        step();
        step();
        ROLL = 1'b1;
        cnt = 0;
        for (int i = 3; i <= 7; i++) begin
            step();
            if (VALID) cnt++;
        end
        check_eq("rej_early_valid", cnt, 0);
        check_eq("rej_busy", BUSY, 1'b1);
        check_eq("rej_dice_held", DICE, 3'd0);
        step();
        check_eq("rej_e8_valid", VALID, 1'b1);
        check_eq("rej_e8_dice", DICE, 3'd1);
        check_eq("rej_e8_result", lfsr_result, 7'h01);
        step();
        check_eq("rej_e9_valid", VALID, 1'b0);
        check_eq("rej_e9_busy", BUSY, 1'b0);

        // Held button gives one draw; re-press gives another
        ROLL = 1'b0;
        step();
        ROLL = 1'b1;
        cnt = 0;
        repeat (50) begin
            step();
            if (VALID) cnt++;
        end
        check_eq("held_pulses", cnt, 1);
        ROLL = 1'b0;
        step();
        ROLL = 1'b1;
        cnt = 0;
        repeat (10) begin
            step();
            if (VALID) cnt++;
        end
        check_eq("repress_pulses", cnt, 1);
        check_eq("repress_range", (DICE >= 3'd1) && (DICE <= 3'd6), 1'b1);
        ROLL = 1'b0;
        step();

        // Mid-draw reset: ROLL at e3, RESET at e5
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        step();
        step();
        ROLL = 1'b1;
        step();
        check_eq("mid_e3_busy", BUSY, 1'b1);
        cnt = (VALID) ? 1 : 0;
        step();
        if (VALID) cnt++;
        RESET = 1'b1;
        step();
        if (VALID) cnt++;
        check_eq("mid_no_valid", cnt, 0);
        check_eq("mid_busy", BUSY, 1'b0);
        check_eq("mid_dice", DICE, 3'd0);
        check_eq("mid_result", lfsr_result, 7'h7F);
        ROLL = 1'b0;
        step();
        RESET = 1'b0;
        ROLL  = 1'b1;
        step();
        step();
        check_eq("mid_next_valid", VALID, 1'b1);
        check_eq("mid_next_dice", DICE, 3'd6);
        check_eq("mid_next_result", lfsr_result, 7'h7E);
        ROLL = 1'b0;
        step();
        step();

`ifdef DICE_RNG_SEED_EN
        // Zero seed maps to 7F: next draw sees 7E -> 6
        SEED_LOAD = 1'b1;
        SEED      = 7'h00;
        step();
        SEED_LOAD = 1'b0;
        ROLL      = 1'b1;
        step();
        step();
        check_eq("seed0_valid", VALID, 1'b1);
        check_eq("seed0_dice", DICE, 3'd6);
        check_eq("seed0_result", lfsr_result, 7'h7E);
        ROLL = 1'b0;
        step();
        step();

        // Seed 05 steps to 0A -> candidate 2
        SEED_LOAD = 1'b1;
        SEED      = 7'h05;
        step();
        SEED_LOAD = 1'b0;
        ROLL      = 1'b1;
        step();
        step();
        check_eq("seed5_valid", VALID, 1'b1);
        check_eq("seed5_dice", DICE, 3'd2);
        check_eq("seed5_result", lfsr_result, 7'h0A);
        ROLL = 1'b0;
        step();
        step();

        for (int r = 0; r < 500; r++) begin
            ROLL = 1'b1;
            n = 0;
            for (int k = 1; k <= 10; k++) begin
                step();
                if (VALID) begin
                    n = k;
                    break;
                end
            end
            check_eq("rand_latency", (n >= 2) && (n <= 7), 1'b1);
            check_eq("rand_range", (DICE >= 3'd1) && (DICE <= 3'd6), 1'b1);
            ROLL = 1'b0;
            repeat ($urandom_range(1, 3)) step();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
